// File: rtl/ioctl_pkg.sv
// Shared types and constants for the HPS upload (read-back) path.
package ioctl_pkg;

    // Upload reader control states.
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        READY,
        FETCH
    } state_t;

    // Byte returned for reads beyond the exposed RAM window.
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Width of the RAM read-latency counter (latency 1..3).
    localparam int LAT_W = 2;

endpackage

// File: rtl/ioctl_upload_reader_if.sv
// HPS ioctl read-back signals plus the core RAM port request/read signals.
interface ioctl_upload_reader_if #(
    parameter int AW = 10
) ();

    // HPS side
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;

    // Core RAM side
    logic          bus_req;
    logic          bus_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_dout;

    // The upload reader itself.
    modport master (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait,
        output bus_req,
        input  bus_gnt,
        output mem_addr,
        output mem_rd,
        input  mem_dout
    );

    // The surroundings: HPS plus the core RAM port.
    modport slave (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait,
        input  bus_req,
        output bus_gnt,
        input  mem_addr,
        input  mem_rd,
        output mem_dout
    );

endinterface

// File: rtl/ioctl_upload_reader.sv
// Serves HPS upload reads from a core byte RAM: requests the RAM port,
// then fetches each requested byte with a fixed read latency.
module ioctl_upload_reader
    import ioctl_pkg::*;
#(
    parameter int         AW     = 10,
    parameter int         SIZE   = 1024,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] INDEX  = 8'd4
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    ioctl_upload_reader_if.master   io
);

    // Full-width bound so high address bits never alias into the RAM window.
    localparam logic [24:0] SIZE_L = 25'(SIZE);

    state_t           state_q,    state_d;
    logic             upload_q,   upload_d;
    logic [LAT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]       din_q,      din_d;
    logic             wait_q,     wait_d;
    logic             bus_req_q,  bus_req_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             mem_rd_q,   mem_rd_d;

    logic upload_rise;
    logic addr_in_range;

    assign upload_rise   = io.ioctl_upload & ~upload_q;
    assign addr_in_range = (io.ioctl_addr < SIZE_L);

    // Next-state and next-output computation for the upload FSM.
    always_comb begin
        state_d    = state_q;
        upload_d   = io.ioctl_upload;
        cnt_d      = cnt_q;
        din_d      = din_q;
        wait_d     = wait_q;
        bus_req_d  = bus_req_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Reads arriving here (even with the upload rise) are dropped.
                if (upload_rise && (io.ioctl_index == INDEX)) begin
                    state_d   = GRANT;
                    bus_req_d = 1'b1;
                    wait_d    = 1'b1;
                end
            end

            GRANT: begin
                if (!io.ioctl_upload) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    wait_d    = 1'b0;
                end else if (io.bus_gnt) begin
                    state_d = READY;
                    wait_d  = 1'b0;
                end
            end

            READY: begin
                if (!io.ioctl_upload) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    wait_d    = 1'b0;
                end else if (io.ioctl_rd) begin
                    if (addr_in_range) begin
                        state_d    = FETCH;
                        mem_addr_d = io.ioctl_addr[AW-1:0];
                        mem_rd_d   = 1'b1;
                        wait_d     = 1'b1;
                        cnt_d      = LAT_W'(RD_LAT);
                    end else begin
                        din_d = FILL_BYTE;
                    end
                end
            end

            FETCH: begin
                // An upload drop is handled once back in READY, so the byte
                // is always latched and bus_req falls one cycle later.
                if (cnt_q == '0) begin
                    state_d = READY;
                    din_d   = io.mem_dout;
                    wait_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; upload history resets high so an upload
    // held across reset needs a fresh rising edge to start a session.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            upload_q   <= 1'b1;
            cnt_q      <= '0;
            din_q      <= 8'h00;
            wait_q     <= 1'b0;
            bus_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            upload_q   <= upload_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            wait_q     <= wait_d;
            bus_req_q  <= bus_req_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    assign io.ioctl_din  = din_q;
    assign io.ioctl_wait = wait_q;
    assign io.bus_req    = bus_req_q;
    assign io.mem_addr   = mem_addr_q;
    assign io.mem_rd     = mem_rd_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: two instances (read latency 1 and 3) driven
// by the same HPS stimulus, each with its own latency-accurate RAM model.
module tb_ioctl_upload_reader;

    localparam int AW   = 10;
    localparam int SIZE = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        upload;
    logic [7:0]  index;
    logic        rd;
    logic [24:0] addr;
    logic        gnt;

    logic [7:0]  mem [SIZE];
    int          lat [2] = '{1, 3};

    ioctl_upload_reader_if #(.AW(AW)) if1 ();
    ioctl_upload_reader_if #(.AW(AW)) if3 ();

    assign if1.ioctl_upload = upload;
    assign if1.ioctl_index  = index;
    assign if1.ioctl_rd     = rd;
    assign if1.ioctl_addr   = addr;
    assign if1.bus_gnt      = gnt;
    assign if3.ioctl_upload = upload;
    assign if3.ioctl_index  = index;
    assign if3.ioctl_rd     = rd;
    assign if3.ioctl_addr   = addr;
    assign if3.bus_gnt      = gnt;

    ioctl_upload_reader #(.AW(AW), .SIZE(SIZE), .RD_LAT(1), .INDEX(8'd4)) dut1 (
        .clk_sys (clk),
        .reset_n (reset_n),
        .io      (if1.master)
    );

    ioctl_upload_reader #(.AW(AW), .SIZE(SIZE), .RD_LAT(3), .INDEX(8'd4)) dut3 (
        .clk_sys (clk),
        .reset_n (reset_n),
        .io      (if3.master)
    );

    // RAM models: data appears exactly RD_LAT cycles after a mem_rd strobe and
    // is junk otherwise, so a mistimed capture or a missing strobe shows up.
    logic [7:0] p1;
    logic [7:0] p3 [3];
    always @(posedge clk) begin
        p1    <= if1.mem_rd ? mem[if1.mem_addr] : 8'h5A;
        p3[0] <= if3.mem_rd ? mem[if3.mem_addr] : 8'h3C;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.mem_dout = p1;
    assign if3.mem_dout = p3[2];

    // Strobe monitors: count mem_rd high cycles and remember the address.
    int         mrd_n [2] = '{0, 0};
    logic [9:0] mrd_a [2];
    always @(posedge clk) begin
        if (if1.mem_rd) begin
            mrd_n[0] <= mrd_n[0] + 1;
            mrd_a[0] <= if1.mem_addr;
        end
        if (if3.mem_rd) begin
            mrd_n[1] <= mrd_n[1] + 1;
            mrd_a[1] <= if3.mem_addr;
        end
    end

    logic [7:0] din   [2];
    logic       wt    [2];
    logic       breq  [2];
    logic       mrd   [2];
    logic [9:0] maddr [2];
    assign din[0]   = if1.ioctl_din;
    assign din[1]   = if3.ioctl_din;
    assign wt[0]    = if1.ioctl_wait;
    assign wt[1]    = if3.ioctl_wait;
    assign breq[0]  = if1.bus_req;
    assign breq[1]  = if3.bus_req;
    assign mrd[0]   = if1.mem_rd;
    assign mrd[1]   = if3.mem_rd;
    assign maddr[0] = if1.mem_addr;
    assign maddr[1] = if3.mem_addr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One HPS read. mode 0: plain; 1: extra ioctl_rd while fetching;
    // 2: upload drops right after the read is accepted.
    task automatic do_read(input logic [24:0] a, input int mode);
        logic [7:0] exp_b;
        bit         inr;
        int         wfall [2];
        int         bfall [2];
        int         whigh [2];
        int         base  [2];
        inr   = (a < 25'(SIZE));
        exp_b = inr ? mem[a[AW-1:0]] : 8'hFF;
        for (int d = 0; d < 2; d++) begin
            base[d]  = mrd_n[d];
            wfall[d] = 0;
            bfall[d] = 0;
            whigh[d] = 0;
        end
        rd   = 1'b1;
        addr = a;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) begin
                rd   = (mode == 1);
                addr = a ^ 25'h155;
                if (mode == 2) upload = 1'b0;
            end else begin
                rd = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                if (wt[d]) whigh[d]++;
                else if (wfall[d] == 0 && whigh[d] > 0) wfall[d] = k;
                if (!breq[d] && bfall[d] == 0) bfall[d] = k;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (inr) begin
                check($sformatf("L%0d wait_fall a=%0h", lat[d], a), wfall[d], lat[d] + 2);
                check($sformatf("L%0d din a=%0h", lat[d], a), din[d], exp_b);
                check($sformatf("L%0d mem_rd_cycles a=%0h", lat[d], a), mrd_n[d] - base[d], 1);
                check($sformatf("L%0d mem_addr a=%0h", lat[d], a), mrd_a[d], a[9:0]);
            end else begin
                check($sformatf("L%0d oor_wait a=%0h", lat[d], a), whigh[d], 0);
                check($sformatf("L%0d oor_din a=%0h", lat[d], a), din[d], 8'hFF);
                check($sformatf("L%0d oor_mem_rd a=%0h", lat[d], a), mrd_n[d] - base[d], 0);
            end
            if (mode == 2)
                check($sformatf("L%0d bus_req_fall", lat[d]), bfall[d], lat[d] + 3);
            else
                check($sformatf("L%0d bus_req_held", lat[d]), breq[d], 1'b1);
        end
    endtask

    initial begin
        int  base [2];
        bit  all_wait [2];
        bit  quiet [2];
        logic [24:0] ra;

        reset_n = 1'b0;
        upload  = 1'b1;
        index   = 8'd4;
        rd      = 1'b0;
        addr    = '0;
        gnt     = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        mem[10'h012] = 8'hA5;

        // Reset with upload held high.
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d rst_din", lat[d]), din[d], 8'h00);
            check($sformatf("L%0d rst_wait", lat[d]), wt[d], 1'b0);
            check($sformatf("L%0d rst_bus_req", lat[d]), breq[d], 1'b0);
            check($sformatf("L%0d rst_mem_addr", lat[d]), maddr[d], 10'h000);
            check($sformatf("L%0d rst_mem_rd", lat[d]), mrd[d], 1'b0);
        end
        reset_n = 1'b1;
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d held_upload_bus_req", lat[d]), breq[d], 1'b0);
            check($sformatf("L%0d held_upload_wait", lat[d]), wt[d], 1'b0);
        end

        // Fresh rise with a simultaneous read (dropped), grant 5 cycles later,
        // and a read during GRANT (dropped).
        upload = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) base[d] = mrd_n[d];
        upload = 1'b1;
        rd     = 1'b1;
        addr   = 25'h012;
        tick();
        rd = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d start_bus_req", lat[d]), breq[d], 1'b1);
            all_wait[d] = wt[d];
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            rd = (i == 1);
            for (int d = 0; d < 2; d++) all_wait[d] = all_wait[d] & wt[d];
        end
        rd  = 1'b0;
        gnt = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d grant_wait_held", lat[d]), all_wait[d], 1'b1);
            check($sformatf("L%0d granted_wait", lat[d]), wt[d], 1'b0);
            check($sformatf("L%0d granted_bus_req", lat[d]), breq[d], 1'b1);
            check($sformatf("L%0d ignored_rd_mem_rd", lat[d]), mrd_n[d] - base[d], 0);
        end

        // Directed and random reads.
        do_read(25'h012, 0);
        do_read(25'h400, 0);
        do_read(25'h1000012, 0);
        do_read(25'h3FF, 0);
        do_read(25'h000, 1);
        for (int i = 0; i < 8; i++) begin
            ra = 25'($urandom_range(0, SIZE - 1));
            do_read(ra, ($urandom_range(0, 1) == 1) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            ra = 25'($urandom_range(SIZE, 25'h1FFFFFF));
            do_read(ra, 0);
        end

        // Upload drops mid-fetch.
        do_read(25'($urandom_range(0, SIZE - 1)), 2);

        // Non-matching index never requests the bus.
        index  = 8'd2;
        upload = 1'b1;
        for (int d = 0; d < 2; d++) quiet[d] = 1'b1;
        repeat (6) begin
            tick();
            for (int d = 0; d < 2; d++) quiet[d] = quiet[d] & ~breq[d] & ~wt[d];
        end
        for (int d = 0; d < 2; d++)
            check($sformatf("L%0d wrong_index_quiet", lat[d]), quiet[d], 1'b1);
        upload = 1'b0;
        tick();

        // Reset in the middle of a fetch.
        index  = 8'd4;
        upload = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) base[d] = mrd_n[d];
        rd   = 1'b1;
        addr = 25'h005;
        tick();
        rd = 1'b0;
        for (int d = 0; d < 2; d++)
            check($sformatf("L%0d pre_reset_mem_rd", lat[d]), mrd[d], 1'b1);
        #1 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d midrst_mem_rd", lat[d]), mrd[d], 1'b0);
            check($sformatf("L%0d midrst_wait", lat[d]), wt[d], 1'b0);
            check($sformatf("L%0d midrst_bus_req", lat[d]), breq[d], 1'b0);
            check($sformatf("L%0d midrst_din", lat[d]), din[d], 8'h00);
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("L%0d midrst_no_strobe", lat[d]), mrd_n[d] - base[d], 0);
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
